// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One transaction in flight: accept (IDLE) -> ALU evaluate (EXEC) -> hold result (RESP).
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_ctr,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_ctr,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_out,
  output logic                  rsp_less,
  output logic                  rsp_zero,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctr,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_less,
  input  logic                  alu_zero
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  rr_ptr;
  logic                  owner;
  logic                  grant;
  logic                  accept;
  logic                  rsp_take;
  logic [DATA_WIDTH-1:0] issue_a;
  logic [DATA_WIDTH-1:0] issue_b;
  logic [3:0]            issue_ctr;
  logic [DATA_WIDTH-1:0] res_out;
  logic                  res_less;
  logic                  res_zero;

  // Priority holder wins if valid, otherwise the other side; the result only
  // matters when the selected side is valid since ready is qualified below.
  always_comb begin
    grant = rr_ptr ? req1_valid : ~req0_valid;
  end

  always_comb begin
    req0_ready = (state == IDLE) & ~grant & req0_valid;
    req1_ready = (state == IDLE) &  grant & req1_valid;
    accept     = req0_ready | req1_ready;
    rsp_take   = owner ? rsp1_ready : rsp0_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      issue_a   <= '0;
      issue_b   <= '0;
      issue_ctr <= '0;
    end else if (accept) begin
      rr_ptr    <= ~grant;
      owner     <= grant;
      issue_a   <= grant ? req1_a   : req0_a;
      issue_b   <= grant ? req1_b   : req0_b;
      issue_ctr <= grant ? req1_ctr : req0_ctr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_out  <= '0;
      res_less <= 1'b0;
      res_zero <= 1'b0;
    end else if (state == EXEC) begin
      res_out  <= alu_out;
      res_less <= alu_less;
      res_zero <= alu_zero;
    end
  end

  always_comb begin
    rsp0_valid = (state == RESP) & ~owner;
    rsp1_valid = (state == RESP) &  owner;
    rsp_out    = res_out;
    rsp_less   = res_less;
    rsp_zero   = res_zero;
    alu_a      = issue_a;
    alu_b      = issue_b;
    alu_ctr    = issue_ctr;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU stub
// and a transaction-level arbitration model.
module tb_alu_arbiter;

  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [DW-1:0] out;
    logic          less;
    logic          zero;
  } alu_res_t;

  typedef struct packed {
    logic     owner;
    alu_res_t res;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_ctr, req1_ctr;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_out;
  logic          rsp_less, rsp_zero;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [3:0]    alu_ctr;
  logic          alu_less, alu_zero;
  alu_res_t      alu_r;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctr(req0_ctr),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctr(req1_ctr),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_out(rsp_out), .rsp_less(rsp_less), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_out(alu_out), .alu_less(alu_less), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic alu_res_t ref_alu(logic [DW-1:0] a, logic [DW-1:0] b, logic [3:0] ctr);
    alu_res_t r;
    r.less = ($signed(a) < $signed(b));
    case (ctr)
      4'd0:    r.out = a + b;
      4'd1:    r.out = a - b;
      4'd2:    r.out = {{(DW-1){1'b0}}, r.less};
      4'd3:    r.out = a & b;
      4'd4:    r.out = a | b;
      4'd5:    r.out = a ^ b;
      default: r.out = a ^ ~b ^ {28'd0, ctr};
    endcase
    r.zero = (r.out == '0);
    return r;
  endfunction

  always_comb begin
    alu_r    = ref_alu(alu_a, alu_b, alu_ctr);
    alu_out  = alu_r.out;
    alu_less = alu_r.less;
    alu_zero = alu_r.zero;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predictor: decides each handshake from the arbitration rules and pushes the expected result.
  int            m_phase = 0;
  logic          m_rr = 1'b0;
  logic          m_owner = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [3:0]    m_ctr = '0;

  initial forever begin
    logic e_r0, e_r1, w;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      m_phase = 0; m_rr = 1'b0; m_owner = 1'b0;
      exp_q.delete();
    end else begin
      e_r0 = (m_phase == 0) && req0_valid && (!req1_valid || !m_rr);
      e_r1 = (m_phase == 0) && req1_valid && (!req0_valid || m_rr);
      check("req0_ready", 64'(req0_ready), 64'(e_r0));
      check("req1_ready", 64'(req1_ready), 64'(e_r1));
      check("rsp0_valid", 64'(rsp0_valid), 64'(m_phase == 2 && !m_owner));
      check("rsp1_valid", 64'(rsp1_valid), 64'(m_phase == 2 && m_owner));
      if (m_phase == 1) begin
        check("exec_alu_a", 64'(alu_a), 64'(m_a));
        check("exec_alu_b", 64'(alu_b), 64'(m_b));
        check("exec_alu_ctr", 64'(alu_ctr), 64'(m_ctr));
      end
      case (m_phase)
        0: if (e_r0 || e_r1) begin
          w       = e_r1;
          m_a     = w ? req1_a : req0_a;
          m_b     = w ? req1_b : req0_b;
          m_ctr   = w ? req1_ctr : req0_ctr;
          e.owner = w;
          e.res   = ref_alu(m_a, m_b, m_ctr);
          exp_q.push_back(e);
          m_owner = w;
          m_rr    = ~w;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (m_owner ? rsp1_ready : rsp0_ready) m_phase = 0;
      endcase
    end
  end

  // Monitor: whenever a response is presented, compare it with the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && (rsp0_valid || rsp1_valid)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_q[0];
        check("rsp_owner", 64'(rsp1_valid), 64'(e.owner));
        check("rsp_out", 64'(rsp_out), 64'(e.res.out));
        check("rsp_less", 64'(rsp_less), 64'(e.res.less));
        check("rsp_zero", 64'(rsp_zero), 64'(e.res.zero));
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(bit v0, bit v1, bit r0, bit r1);
    @(posedge clk);
    #1;
    req0_valid = v0; req1_valid = v1;
    rsp0_ready = r0; rsp1_ready = r1;
    req0_a = $urandom; req1_a = $urandom;
    req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
    req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
    req0_ctr = 4'($urandom_range(0, 15));
    req1_ctr = 4'($urandom_range(0, 15));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_rsp0_valid"}, 64'(rsp0_valid), 64'(0));
    check({tag, "_rsp1_valid"}, 64'(rsp1_valid), 64'(0));
    check({tag, "_rsp_out"}, 64'(rsp_out), 64'(0));
    check({tag, "_rsp_less"}, 64'(rsp_less), 64'(0));
    check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(0));
    check({tag, "_alu_a"}, 64'(alu_a), 64'(0));
    check({tag, "_alu_b"}, 64'(alu_b), 64'(0));
    check({tag, "_alu_ctr"}, 64'(alu_ctr), 64'(0));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctr = '0;
    req1_a = '0; req1_b = '0; req1_ctr = '0;
    #3;
    check_reset_outputs("reset");
    check("reset_req0_ready", 64'(req0_ready), 64'(0));
    check("reset_req1_ready", 64'(req1_ready), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single add on requester 0: 5 + 3.
    step(1, 0, 1, 1);
    req0_a = 32'd5; req0_b = 32'd3; req0_ctr = 4'd0;
    repeat (4) step(0, 0, 1, 1);

    // Signed compare with the most negative value on requester 1.
    step(0, 1, 1, 1);
    req1_a = 32'h8000_0000; req1_b = 32'd1; req1_ctr = 4'd2;
    repeat (4) step(0, 0, 1, 1);

    // Continuous contention.
    repeat (14) step(1, 1, 1, 1);
    repeat (4) step(0, 0, 1, 1);

    // Backpressure on requester 1 while requester 0 keeps asking; rsp0_ready is a wrong-owner ready.
    step(0, 1, 1, 0);
    repeat (12) step(1, 0, 1, 0);
    repeat (4) step(0, 0, 1, 1);

    // Owner 0 with only the other side's ready asserted.
    step(1, 0, 0, 1);
    repeat (6) step(0, 0, 0, 1);
    repeat (3) step(0, 0, 1, 1);

    // Random traffic including drop-before-ready and stalls.
    repeat (400) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    repeat (4) step(0, 0, 1, 1);

    // Asynchronous reset while a response is pending.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("resp_wait_timeout", 64'(seen), 64'(1));
    @(posedge clk);
    #3;
    req0_valid = 1'b0; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    check("async_reset_req0_ready", 64'(req0_ready), 64'(0));
    check("async_reset_req1_ready", 64'(req1_ready), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) step(1, 1, 1, 1);
    repeat (5) step(0, 0, 1, 1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
